// File: rtl/shift_seq.sv
// -----------------------------------------------------------------------------
// shift_seq: multi-cycle barrel-shift unit. It takes one request through a
// valid/ready handshake, shifts the operand by one bit position per clock,
// and holds the result until the consumer takes it.
//
// Parameters:
//   WIDTH    operand/result width. Must be a power of two >= 2; any other
//            value stops elaboration with an error.
//   SHAMT_W  (localparam) shift-amount width, $clog2(WIDTH)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   request valid
//   in_ready   request can be accepted (IDLE only)
//   din        operand
//   shamt      shift amount, 0..WIDTH-1
//   op         00 logical left, 01 logical right, 10 arithmetic right,
//              11 rotate right (logical right when rotate is not built)
//   out_valid  result valid (DONE only)
//   out_ready  consumer takes the result
//   dout       result register (meaningful while out_valid)
//   busy       high in SHIFT or DONE
//
// Build option:
//   SHIFT_SEQ_ROTATE_EN  when defined, op=11 rotates right. When undefined,
//                        the rotate path is not built and op=11 behaves
//                        exactly as op=01.
// -----------------------------------------------------------------------------
module shift_seq #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           din,
    input  logic [$clog2(WIDTH)-1:0]   shamt,
    input  logic [1:0]                 op,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           dout,
    output logic                       busy
);

    localparam int SHAMT_W = $clog2(WIDTH);

    generate
        if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
            $error("shift_seq: WIDTH must be a power of two >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              state_q;
    logic [WIDTH-1:0]    data_q;
    logic [SHAMT_W-1:0]  cnt_q;
    logic [1:0]          op_q;
    logic                sign_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic                busy_q;

    // One-position shift of the working register, selected by the op
    // captured at accept time.
    logic [WIDTH-1:0]    data_d;

    always_comb begin
        data_d = {1'b0, data_q[WIDTH-1:1]};
        case (op_q)
            2'b00:   data_d = {data_q[WIDTH-2:0], 1'b0};
            2'b01:   data_d = {1'b0, data_q[WIDTH-1:1]};
            // Sign bit is the operand MSB captured at accept, so the fill
            // stays correct however many positions have been shifted.
            2'b10:   data_d = {sign_q, data_q[WIDTH-1:1]};
`ifdef SHIFT_SEQ_ROTATE_EN
            2'b11:   data_d = {data_q[0], data_q[WIDTH-1:1]};
`else
            2'b11:   data_d = {1'b0, data_q[WIDTH-1:1]};
`endif
            default: data_d = {1'b0, data_q[WIDTH-1:1]};
        endcase
    end

    // Control FSM. Handshake flags are registered alongside the state so
    // they change on the same edge as the state they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            data_q      <= '0;
            cnt_q       <= '0;
            op_q        <= 2'b00;
            sign_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        data_q     <= din;
                        cnt_q      <= shamt;
                        op_q       <= op;
                        sign_q     <= din[WIDTH-1];
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (shamt != '0) begin
                            state_q <= S_SHIFT;
                        end else begin
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    data_q <= data_d;
                    cnt_q  <= cnt_q - SHAMT_W'(1);
                    // cnt==1 means this edge performs the last shift.
                    if (cnt_q == SHAMT_W'(1)) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign dout      = data_q;

endmodule

// File: tb/tb_shift_seq.sv
// -----------------------------------------------------------------------------
// tb_shift_seq: self-checking bench for shift_seq. Two instances run side by
// side (WIDTH=8 as index 0, WIDTH=16 as index 1); only one holds a request at
// any time. The driver pushes the expected result into a scoreboard when a
// request is accepted; a monitor process pops and compares when the DUT
// presents a result. Expected results come from a shift model written with
// plain arithmetic on masked integers.
// -----------------------------------------------------------------------------
module tb_shift_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid_s  [2];
    logic        in_ready_s  [2];
    logic [15:0] din_s       [2];
    logic [3:0]  shamt_s     [2];
    logic [1:0]  op_s        [2];
    logic        out_valid_s [2];
    logic        out_ready_s [2];
    logic [15:0] dout_s      [2];
    logic        busy_s      [2];

    int cyc = 0;
    int pass_cnt = 0;
    int chk_cnt = 0;

    typedef struct {
        int          k;
        logic [15:0] val;
        int          acc;
        int          sh;
    } item_t;

    item_t sb[$];
    bit    seen [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int W  = (gi == 0) ? 8 : 16;
        localparam int SW = $clog2(W);
        logic [W-1:0] dout_loc;

        shift_seq #(.WIDTH(W)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid_s[gi]),
            .in_ready  (in_ready_s[gi]),
            .din       (din_s[gi][W-1:0]),
            .shamt     (shamt_s[gi][SW-1:0]),
            .op        (op_s[gi]),
            .out_valid (out_valid_s[gi]),
            .out_ready (out_ready_s[gi]),
            .dout      (dout_loc),
            .busy      (busy_s[gi])
        );

        assign dout_s[gi] = 16'(dout_loc);
    end

    // Reference: full shift by s positions at once.
    function automatic logic [15:0] model(input int w, input logic [15:0] d,
                                          input int s, input logic [1:0] o);
        logic [31:0] m;
        logic [31:0] dd;
        logic [31:0] r;
        m  = (32'd1 << w) - 32'd1;
        dd = {16'h0, d} & m;
        case (o)
            2'b00: r = (dd << s) & m;
            2'b01: r = dd >> s;
            2'b10: begin
                r = dd >> s;
                if (((dd >> (w - 1)) & 32'd1) != 0) r = r | (m & ~(m >> s));
            end
            default: begin
`ifdef SHIFT_SEQ_ROTATE_EN
                r = ((dd >> s) | (dd << (w - s))) & m;
`else
                r = dd >> s;
`endif
            end
        endcase
        return r[15:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int k, input logic [15:0] d, input int s,
                        input logic [1:0] o, input int hold);
        int n;
        item_t it;
        n = 0;
        while (in_ready_s[k] !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("wait_in_ready", in_ready_s[k], 1);
        din_s[k]      = d;
        shamt_s[k]    = 4'(s);
        op_s[k]       = o;
        in_valid_s[k] = 1'b1;
        tick();
        it.k   = k;
        it.val = model((k == 0) ? 8 : 16, d, s, o);
        it.acc = cyc;
        it.sh  = s;
        sb.push_back(it);
        $display("txn dut%0d din=%h shamt=%0d op=%0d exp=%h hold=%0d", k, d, s, o, it.val, hold);
        // Keep requesting with fresh garbage: must neither be accepted nor
        // disturb the operation in flight.
        for (int i = 0; i < 2; i++) begin
            chk("no_accept_busy", in_ready_s[k], 0);
            din_s[k]   = 16'($urandom);
            shamt_s[k] = 4'($urandom);
            op_s[k]    = 2'($urandom);
            tick();
        end
        in_valid_s[k] = 1'b0;
        n = 0;
        while (out_valid_s[k] !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("wait_out_valid", out_valid_s[k], 1);
        if (out_valid_s[k] !== 1'b1) sb.delete();
        repeat (hold) tick();
        out_ready_s[k] = 1'b1;
        tick();
        out_ready_s[k] = 1'b0;
        chk("release_in_ready", in_ready_s[k], 1);
        chk("release_out_valid", out_valid_s[k], 0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            in_valid_s[k]  = 1'b1;
            din_s[k]       = 16'hBEEF;
            shamt_s[k]     = 4'd3;
            op_s[k]        = 2'b00;
            out_ready_s[k] = 1'b0;
            seen[k]        = 1'b0;
        end
        rst_n = 1'b0;

        // Reset held two edges while a request is offered.
        for (int c = 0; c < 2; c++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                chk("rst_in_ready", in_ready_s[k], 1);
                chk("rst_out_valid", out_valid_s[k], 0);
                chk("rst_busy", busy_s[k], 0);
                chk("rst_dout", dout_s[k], 0);
            end
        end

        // Monitor: compares whatever the DUTs present against the scoreboard.
        fork
            forever begin
                @(negedge clk);
                for (int k = 0; k < 2; k++) begin
                    chk("busy_vs_ready", busy_s[k], !in_ready_s[k]);
                    chk("ready_valid_excl", in_ready_s[k] & out_valid_s[k], 0);
                    if (out_valid_s[k] === 1'b1) begin
                        if (sb.size() == 0 || sb[0].k != k) begin
                            chk("unexpected_valid", 1, 0);
                        end else begin
                            if (!seen[k]) begin
                                chk("latency", 32'(cyc - sb[0].acc), 32'(sb[0].sh));
                                seen[k] = 1'b1;
                            end
                            chk("dout", dout_s[k], sb[0].val);
                            if (out_ready_s[k] === 1'b1) begin
                                void'(sb.pop_front());
                                seen[k] = 1'b0;
                            end
                        end
                    end
                end
            end
        join_none

        for (int k = 0; k < 2; k++) in_valid_s[k] = 1'b0;
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            chk("post_rst_idle", in_ready_s[k], 1);
            chk("post_rst_busy", busy_s[k], 0);
        end

        // Directed cases.
        send(0, 16'h00AA, 5, 2'b00, 4);
        send(0, 16'h00AA, 3, 2'b10, 0);
        send(0, 16'h00AA, 2, 2'b01, 1);
        send(0, 16'h00AA, 7, 2'b11, 0);
        send(0, 16'h003C, 0, 2'b01, 2);

        // Reset at the third shift cycle aborts the request.
        din_s[0]      = 16'h00FF;
        shamt_s[0]    = 4'd6;
        op_s[0]       = 2'b00;
        in_valid_s[0] = 1'b1;
        tick();
        in_valid_s[0] = 1'b0;
        $display("txn dut0 din=00ff shamt=6 op=0 aborted by reset");
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sb.delete();
        seen[0] = 1'b0;
        chk("abort_dout", dout_s[0], 0);
        chk("abort_in_ready", in_ready_s[0], 1);
        chk("abort_out_valid", out_valid_s[0], 0);
        chk("abort_busy", busy_s[0], 0);
        repeat (8) tick();

        send(1, 16'h8001, 15, 2'b10, 1);

        // Randomised traffic on both widths.
        for (int i = 0; i < 24; i++) begin
            int k;
            int s;
            logic [15:0] d;
            k = i % 2;
            s = (k == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 15));
            d = 16'($urandom) & ((k == 0) ? 16'h00FF : 16'hFFFF);
            send(k, d, s, 2'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        repeat (3) tick();
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
